// File: rtl/rv32i_alu_pkg.sv
// Shared RV32I opcode/funct constants and ALU-side encodings used by the
// issue stage and its decode sub-module.
package rv32i_alu_pkg;

  // RV32I major opcodes handled by the ALU issue path
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // RV32I funct3 values for OP / OP-IMM
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // RV32I funct7 values (also imm[11:5] for shift-immediates)
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU operation class
  typedef enum logic [1:0] {
    ALUOP_ARITH = 2'b00,
    ALUOP_LOGIC = 2'b01,
    ALUOP_SHIFT = 2'b10,
    ALUOP_CMP   = 2'b11
  } alu_op_e;

  // ALU-side funct3 codes within each class
  localparam logic [2:0] ALU_F3_ADD  = 3'b000;
  localparam logic [2:0] ALU_F3_AND  = 3'b000;
  localparam logic [2:0] ALU_F3_OR   = 3'b001;
  localparam logic [2:0] ALU_F3_XOR  = 3'b010;
  localparam logic [2:0] ALU_F3_SLL  = 3'b000;
  localparam logic [2:0] ALU_F3_SR   = 3'b101;
  localparam logic [2:0] ALU_F3_SLT  = 3'b010;
  localparam logic [2:0] ALU_F3_SLTU = 3'b011;

  // ALU-side funct7 codes
  localparam logic [6:0] ALU_F7_NONE = 7'b0000000;
  localparam logic [6:0] ALU_F7_ALT  = 7'b0100000;

  // Decoded fields handed from the decoder to the issue register
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    alu_op_e     aluop;
    logic [2:0]  funct3;
    logic [4:0]  shamt;
    logic [6:0]  funct7;
    logic        illegal;
  } alu_fields_t;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_op_map.sv
// Combinational RV32I OP/OP-IMM -> ALU field mapping with illegal detection.
// Takes only the instruction fields it needs (opcode, funct3, imm[11:0]);
// imm[11:5] doubles as funct7 and imm[4:0] as the shift-immediate.
module alu_op_map
  import rv32i_alu_pkg::*;
(
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [11:0] i_imm,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output alu_fields_t o_fields
);

  logic [6:0] w_f7;
  logic       w_is_op;
  logic       w_legal;
  logic       w_alt;

  assign w_f7    = i_imm[11:5];
  assign w_is_op = (i_opcode == OPC_OP);

  // Decode operands, ALU class/codes and legality; illegal zeroes all fields
  always_comb begin
    o_fields        = '0;
    w_legal         = 1'b0;
    w_alt           = 1'b0;
    o_fields.a      = i_rs1_data;
    o_fields.aluop  = ALUOP_ARITH;

    case (i_opcode)
      OPC_OP: begin
        o_fields.b     = i_rs2_data;
        o_fields.shamt = i_rs2_data[4:0];
        w_legal        = (w_f7 == F7_BASE) ||
                         ((w_f7 == F7_ALT) &&
                          ((i_funct3 == F3_ADD_SUB) || (i_funct3 == F3_SRL_SRA)));
      end
      OPC_OP_IMM: begin
        o_fields.b     = sext12(i_imm);
        o_fields.shamt = i_imm[4:0];
        case (i_funct3)
          F3_SLL:     w_legal = (w_f7 == F7_BASE);
          F3_SRL_SRA: w_legal = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
          default:    w_legal = 1'b1;
        endcase
      end
      default: w_legal = 1'b0;
    endcase

    case (i_funct3)
      F3_ADD_SUB: begin
        o_fields.aluop  = ALUOP_ARITH;
        o_fields.funct3 = ALU_F3_ADD;
        // Only register-register form can subtract; ADDI imm bits are ignored
        w_alt           = w_is_op && (w_f7 == F7_ALT);
      end
      F3_SLL: begin
        o_fields.aluop  = ALUOP_SHIFT;
        o_fields.funct3 = ALU_F3_SLL;
      end
      F3_SLT: begin
        o_fields.aluop  = ALUOP_CMP;
        o_fields.funct3 = ALU_F3_SLT;
      end
      F3_SLTU: begin
        o_fields.aluop  = ALUOP_CMP;
        o_fields.funct3 = ALU_F3_SLTU;
      end
      F3_XOR: begin
        o_fields.aluop  = ALUOP_LOGIC;
        o_fields.funct3 = ALU_F3_XOR;
      end
      F3_SRL_SRA: begin
        o_fields.aluop  = ALUOP_SHIFT;
        o_fields.funct3 = ALU_F3_SR;
        w_alt           = (w_f7 == F7_ALT);
      end
      F3_OR: begin
        o_fields.aluop  = ALUOP_LOGIC;
        o_fields.funct3 = ALU_F3_OR;
      end
      default: begin
        o_fields.aluop  = ALUOP_LOGIC;
        o_fields.funct3 = ALU_F3_AND;
      end
    endcase

    o_fields.funct7 = w_alt ? ALU_F7_ALT : ALU_F7_NONE;

    if (!w_legal) begin
      o_fields         = '0;
      o_fields.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: single-entry issue register between fetch and the ALU,
// with register-file read addressing, flush, and optional performance
// counters enabled by defining ALU_ISSUE_PERF_EN.
module alu_issue_stage
  import rv32i_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_A,
  output logic [31:0] out_B,
  output logic [1:0]  out_ALUOp,
  output logic [2:0]  out_funct3,
  output logic [4:0]  out_shamt,
  output logic [6:0]  out_funct7,
  output logic [4:0]  out_rd,
  output logic        out_illegal,
  input  logic        flush
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_illegal
`endif
);

  alu_fields_t w_fields;
  alu_fields_t r_fields;
  logic        r_valid;
  logic [4:0]  r_rd;
  logic        w_accept;

  assign rf_rs1_addr = instr[19:15];
  assign rf_rs2_addr = instr[24:20];

  assign in_ready = !rst && !flush && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  alu_op_map u_map (
    .i_opcode   (instr[6:0]),
    .i_funct3   (instr[14:12]),
    .i_imm      (instr[31:20]),
    .i_rs1_data (rf_rs1_data),
    .i_rs2_data (rf_rs2_data),
    .o_fields   (w_fields)
  );

  // Issue register: reset, flush, load on accept, drain on downstream take
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_fields <= '0;
      r_rd     <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_fields <= w_fields;
      r_rd     <= instr[11:7];
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_A       = r_fields.a;
  assign out_B       = r_fields.b;
  assign out_ALUOp   = r_fields.aluop;
  assign out_funct3  = r_fields.funct3;
  assign out_shamt   = r_fields.shamt;
  assign out_funct7  = r_fields.funct7;
  assign out_illegal = r_fields.illegal;
  assign out_rd      = r_rd;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_illegal;
  logic        w_xfer;

  // A flushed entry never completes a transfer, so it is never counted
  assign w_xfer = r_valid && out_ready && !flush;

  // Free-running transfer counters, wrapping naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_issued  <= '0;
      r_perf_illegal <= '0;
    end else if (w_xfer) begin
      r_perf_issued <= r_perf_issued + 32'd1;
      if (r_fields.illegal) begin
        r_perf_illegal <= r_perf_illegal + 32'd1;
      end
    end
  end

  assign perf_issued  = r_perf_issued;
  assign perf_illegal = r_perf_illegal;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
// Define ALU_ISSUE_PERF_EN to also exercise the performance counters.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_A;
  logic [31:0] out_B;
  logic [1:0]  out_ALUOp;
  logic [2:0]  out_funct3;
  logic [4:0]  out_shamt;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic        flush;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_illegal;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] tb_rf [32];
  assign rf_rs1_data = tb_rf[rf_rs1_addr];
  assign rf_rs2_data = tb_rf[rf_rs2_addr];

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .rf_rs1_addr (rf_rs1_addr),
    .rf_rs2_addr (rf_rs2_addr),
    .rf_rs1_data (rf_rs1_data),
    .rf_rs2_data (rf_rs2_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_A       (out_A),
    .out_B       (out_B),
    .out_ALUOp   (out_ALUOp),
    .out_funct3  (out_funct3),
    .out_shamt   (out_shamt),
    .out_funct7  (out_funct7),
    .out_rd      (out_rd),
    .out_illegal (out_illegal),
    .flush       (flush)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_issued  (perf_issued),
    .perf_illegal (perf_illegal)
`endif
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  sh;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  vec_t vecs[18];

  function automatic logic [87:0] got_bus();
    return {out_valid, out_A, out_B, out_ALUOp, out_funct3, out_funct7,
            out_shamt, out_rd, out_illegal};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    instr = 32'h0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    instr = 32'h002081B3;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    end
    step();
    total++;
    if (got_bus() !== 88'h0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", got_bus());
    end
`ifdef ALU_ISSUE_PERF_EN
    total++;
    if ({perf_issued, perf_illegal} !== 64'h0) begin
      bad++; $display("FAIL reset_perf got=%h/%h exp=0/0", perf_issued, perf_illegal);
    end
`endif
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset_ready got=%b exp=1", in_ready);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_rd !== 5'd3) begin
      bad++; $display("FAIL post_reset_accept got v=%b rd=%0d exp v=1 rd=3", out_valid, out_rd);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_add();
    in_valid = 1'b1; out_ready = 1'b1; instr = 32'h002081B3;
    #1;
    total++;
    if (rf_rs1_addr !== 5'd1 || rf_rs2_addr !== 5'd2) begin
      bad++; $display("FAIL add_rf_addr got=%0d,%0d exp=1,2", rf_rs1_addr, rf_rs2_addr);
    end
    step();
    in_valid = 1'b0;
    total++;
    if (got_bus() !== {1'b1, 32'd5, 32'd7, 2'b00, 3'b000, 7'b0, 5'd7, 5'd3, 1'b0}) begin
      bad++; $display("FAIL add_issue got v=%b A=%h B=%h op=%b f3=%b f7=%b rd=%0d exp v=1 A=5 B=7 op=00 f3=000 f7=0 rd=3",
                      out_valid, out_A, out_B, out_ALUOp, out_funct3, out_funct7, out_rd);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL add_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_addi();
    in_valid = 1'b1; out_ready = 1'b1; instr = 32'hFFF00093;
    step();
    in_valid = 1'b0;
    total++;
    if (out_B !== 32'hFFFFFFFF || out_ALUOp !== 2'b00 || out_funct7 !== 7'b0 ||
        out_illegal !== 1'b0 || out_A !== 32'h0 || out_rd !== 5'd1) begin
      bad++; $display("FAIL addi got A=%h B=%h op=%b f7=%b ill=%b rd=%0d exp A=0 B=ffffffff op=00 f7=0 ill=0 rd=1",
                      out_A, out_B, out_ALUOp, out_funct7, out_illegal, out_rd);
    end
    step();
  endtask

  task automatic test_srai();
    in_valid = 1'b1; out_ready = 1'b1; instr = 32'h40335293;
    step();
    in_valid = 1'b0;
    total++;
    if (got_bus() !== {1'b1, 32'h80000000, 32'h00000403, 2'b10, 3'b101, 7'b0100000,
                       5'd3, 5'd5, 1'b0}) begin
      bad++; $display("FAIL srai got A=%h B=%h op=%b f3=%b f7=%b sh=%0d rd=%0d exp A=80000000 B=403 op=10 f3=101 f7=0100000 sh=3 rd=5",
                      out_A, out_B, out_ALUOp, out_funct3, out_funct7, out_shamt, out_rd);
    end
    step();
  endtask

  task automatic test_decode_b2b();
    logic [87:0] exp;
    vecs[0]  = '{32'h002081B3, 32'd5, 32'd7, 2'b00, 3'b000, 7'h00, 5'd7, 5'd3, 1'b0};
    vecs[1]  = '{32'h402081B3, 32'd5, 32'd7, 2'b00, 3'b000, 7'h20, 5'd7, 5'd3, 1'b0};
    vecs[2]  = '{32'h002091B3, 32'd5, 32'd7, 2'b10, 3'b000, 7'h00, 5'd7, 5'd3, 1'b0};
    vecs[3]  = '{32'h0020A1B3, 32'd5, 32'd7, 2'b11, 3'b010, 7'h00, 5'd7, 5'd3, 1'b0};
    vecs[4]  = '{32'h0020B1B3, 32'd5, 32'd7, 2'b11, 3'b011, 7'h00, 5'd7, 5'd3, 1'b0};
    vecs[5]  = '{32'h0020C1B3, 32'd5, 32'd7, 2'b01, 3'b010, 7'h00, 5'd7, 5'd3, 1'b0};
    vecs[6]  = '{32'h0020D1B3, 32'd5, 32'd7, 2'b10, 3'b101, 7'h00, 5'd7, 5'd3, 1'b0};
    vecs[7]  = '{32'h4020D1B3, 32'd5, 32'd7, 2'b10, 3'b101, 7'h20, 5'd7, 5'd3, 1'b0};
    vecs[8]  = '{32'h0020E1B3, 32'd5, 32'd7, 2'b01, 3'b001, 7'h00, 5'd7, 5'd3, 1'b0};
    vecs[9]  = '{32'h0020F1B3, 32'd5, 32'd7, 2'b01, 3'b000, 7'h00, 5'd7, 5'd3, 1'b0};
    vecs[10] = '{32'h4020F1B3, 32'd0, 32'd0, 2'b00, 3'b000, 7'h00, 5'd0, 5'd3, 1'b1};
    vecs[11] = '{32'h022081B3, 32'd0, 32'd0, 2'b00, 3'b000, 7'h00, 5'd0, 5'd3, 1'b1};
    vecs[12] = '{32'hFFF0C093, 32'd5, 32'hFFFFFFFF, 2'b01, 3'b010, 7'h00, 5'd31, 5'd1, 1'b0};
    vecs[13] = '{32'h02009093, 32'd0, 32'd0, 2'b00, 3'b000, 7'h00, 5'd0, 5'd1, 1'b1};
    vecs[14] = '{32'h0020D093, 32'd5, 32'd2, 2'b10, 3'b101, 7'h00, 5'd2, 5'd1, 1'b0};
    vecs[15] = '{32'h2020D093, 32'd0, 32'd0, 2'b00, 3'b000, 7'h00, 5'd0, 5'd1, 1'b1};
    vecs[16] = '{32'h0000007F, 32'd0, 32'd0, 2'b00, 3'b000, 7'h00, 5'd0, 5'd0, 1'b1};
    vecs[17] = '{32'h40008093, 32'd5, 32'h400, 2'b00, 3'b000, 7'h00, 5'd0, 5'd1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      instr = vecs[i].ins; in_valid = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, in_ready);
      end
      step();
      exp = {1'b1, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].f3, vecs[i].f7,
             vecs[i].sh, vecs[i].rd, vecs[i].ill};
      total++;
      if (got_bus() !== exp) begin
        bad++; $display("FAIL decode[%0d] instr=%h got=%h exp=%h", i, vecs[i].ins, got_bus(), exp);
      end
    end
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3;
    step();
    instr = 32'h402082B3;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_ready[%0d] got=%b exp=0", c, in_ready);
      end
      step();
      total++;
      if (got_bus() !== {1'b1, 32'd5, 32'd7, 2'b00, 3'b000, 7'h00, 5'd7, 5'd3, 1'b0}) begin
        bad++; $display("FAIL bp_hold[%0d] got=%h exp first ADD held", c, got_bus());
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready);
    end
    step();
    in_valid = 1'b0;
    total++;
    if (got_bus() !== {1'b1, 32'd5, 32'd7, 2'b00, 3'b000, 7'h20, 5'd7, 5'd5, 1'b0}) begin
      bad++; $display("FAIL bp_second got=%h exp SUB rd=5", got_bus());
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_illegal_perf();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h0000007F;
    step();
    in_valid = 1'b0;
    total++;
    if (got_bus() !== {1'b1, 32'd0, 32'd0, 2'b00, 3'b000, 7'h00, 5'd0, 5'd0, 1'b1}) begin
      bad++; $display("FAIL illegal_fields got=%h exp valid+illegal only", got_bus());
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL illegal_drain got=%b exp=0", out_valid);
    end
`ifdef ALU_ISSUE_PERF_EN
    total++;
    if (perf_issued !== 32'd1 || perf_illegal !== 32'd1) begin
      bad++; $display("FAIL perf_after_illegal got=%0d/%0d exp=1/1", perf_issued, perf_illegal);
    end
`endif
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3;
    step();
    flush = 1'b1; out_ready = 1'b1; instr = 32'h402082B3;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL flush_ready got=%b exp=0", in_ready);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_clear got=%b exp=0", out_valid);
    end
    flush = 1'b0; in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_nothing_accepted got=%b exp=0", out_valid);
    end
`ifdef ALU_ISSUE_PERF_EN
    total++;
    if (perf_issued !== 32'd0) begin
      bad++; $display("FAIL perf_flush_not_counted got=%0d exp=0", perf_issued);
    end
`endif
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h002081B3;
    step();
    step();
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL rst_mid_ready got=%b exp=0", in_ready);
    end
    step();
    total++;
    if (got_bus() !== 88'h0) begin
      bad++; $display("FAIL rst_mid_outputs got=%h exp=0", got_bus());
    end
    rst = 1'b0; out_ready = 1'b1; instr = 32'hFFF00093;
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_B !== 32'hFFFFFFFF || out_rd !== 5'd1) begin
      bad++; $display("FAIL rst_mid_reaccept got v=%b B=%h rd=%0d exp v=1 B=ffffffff rd=1",
                      out_valid, out_B, out_rd);
    end
    step();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) tb_rf[r] = 32'h0;
    tb_rf[1] = 32'd5;
    tb_rf[2] = 32'd7;
    tb_rf[6] = 32'h80000000;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; instr = 32'h0;
    step();
    test_reset();
    test_add();
    test_addi();
    test_srai();
    test_decode_b2b();
    test_backpressure();
    test_illegal_perf();
    test_flush();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
